// File: rtl/smart_home_pkg.sv
// +-----------------------------------------------------------------------------
// | smart_home_pkg : shared widths and constants for the smart-home core
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package smart_home_pkg;

  localparam int PW_W  = 4;
  localparam int N_DEV = 4;
  localparam int N_PW  = 3;

  localparam logic [N_DEV-1:0] DEV_ALL_OFF = '0;

endpackage : smart_home_pkg

`default_nettype wire

// File: rtl/sh_pw_compare.sv
// +-----------------------------------------------------------------------------
// | sh_pw_compare : combinational three-digit password equality check
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module sh_pw_compare
  import smart_home_pkg::*;
#(
  parameter int PW_W_P = PW_W
) (
  input  logic [PW_W_P-1:0] pdp1_i,
  input  logic [PW_W_P-1:0] pdp2_i,
  input  logic [PW_W_P-1:0] pdp3_i,
  input  logic [PW_W_P-1:0] uep1_i,
  input  logic [PW_W_P-1:0] uep2_i,
  input  logic [PW_W_P-1:0] uep3_i,
  output logic              match_o
);

  assign match_o = (uep1_i == pdp1_i) && (uep2_i == pdp2_i) && (uep3_i == pdp3_i);

endmodule : sh_pw_compare

`default_nettype wire

// File: rtl/smart_home_main.sv
// +-----------------------------------------------------------------------------
// | smart_home_main : security lock plus gated device control, registered outputs
// | Optional idle auto-off timer enabled by macro SMART_HOME_IDLE_TIMEOUT_EN
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module smart_home_main
  import smart_home_pkg::*;
#(
  parameter int PW_W_P      = PW_W,
  parameter int N_DEV_P     = N_DEV,
  parameter int IDLE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Motion_Sensor,
  input  logic               Fire_Detector,
  input  logic [PW_W_P-1:0]  PDP1,
  input  logic [PW_W_P-1:0]  PDP2,
  input  logic [PW_W_P-1:0]  PDP3,
  input  logic [PW_W_P-1:0]  UEP1,
  input  logic [PW_W_P-1:0]  UEP2,
  input  logic [PW_W_P-1:0]  UEP3,
  input  logic [N_DEV_P-1:0] Remote,
  output logic               M,
  output logic [N_DEV_P-1:0] Devices
);

  if (IDLE_CYCLES < 1) begin : g_idle_chk
    $error("IDLE_CYCLES must be at least 1");
  end

  logic               match_c;
  logic               occupied_c;
  logic               m_q;
  logic               m_d;
  logic [N_DEV_P-1:0] dev_q;
  logic [N_DEV_P-1:0] dev_d;

  sh_pw_compare #(
    .PW_W_P (PW_W_P)
  ) u_pw_compare (
    .pdp1_i  (PDP1),
    .pdp2_i  (PDP2),
    .pdp3_i  (PDP3),
    .uep1_i  (UEP1),
    .uep2_i  (UEP2),
    .uep3_i  (UEP3),
    .match_o (match_c)
  );

`ifdef SMART_HOME_IDLE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_d;

  always_comb begin
    idle_d = idle_q;
    if (Motion_Sensor) begin
      idle_d = IDLE_W'(IDLE_CYCLES);
    end else if (idle_q != '0) begin
      idle_d = idle_q - IDLE_W'(1);
    end
  end

  // Counter value before this sample gives exactly IDLE_CYCLES powered samples after motion falls.
  assign occupied_c = Motion_Sensor || (idle_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign occupied_c = Motion_Sensor;
`endif

  always_comb begin
    m_d   = match_c;
    dev_d = N_DEV_P'(DEV_ALL_OFF);
    if (Fire_Detector) begin
      dev_d = N_DEV_P'(DEV_ALL_OFF);
    end else if (!match_c) begin
      dev_d = N_DEV_P'(DEV_ALL_OFF);
    end else if (!occupied_c) begin
      dev_d = N_DEV_P'(DEV_ALL_OFF);
    end else begin
      dev_d = Remote;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= 1'b0;
      dev_q <= '0;
    end else begin
      m_q   <= m_d;
      dev_q <= dev_d;
    end
  end

  assign M       = m_q;
  assign Devices = dev_q;

endmodule : smart_home_main

`default_nettype wire

// File: tb/tb_smart_home_main.sv
// +-----------------------------------------------------------------------------
// | tb_smart_home_main : directed and randomized checks of smart_home_main
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_smart_home_main;

  localparam int IDLE_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       Motion_Sensor;
  logic       Fire_Detector;
  logic [3:0] PDP1, PDP2, PDP3;
  logic [3:0] UEP1, UEP2, UEP3;
  logic [3:0] Remote;
  logic       M;
  logic [3:0] Devices;

  int tests = 0;
  int fails = 0;
  int quiet = 1000000;
  bit seen_motion = 1'b0;

  always #5 clk = ~clk;

  smart_home_main #(
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Motion_Sensor (Motion_Sensor),
    .Fire_Detector (Fire_Detector),
    .PDP1          (PDP1),
    .PDP2          (PDP2),
    .PDP3          (PDP3),
    .UEP1          (UEP1),
    .UEP2          (UEP2),
    .UEP3          (UEP3),
    .Remote        (Remote),
    .M             (M),
    .Devices       (Devices)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample: drive, predict from the rules, clock, compare.
  task automatic cycle(input logic [3:0] p1, p2, p3, u1, u2, u3,
                       input logic mot, fir, input logic [3:0] rem, input string tag);
    logic [3:0] pd[3];
    logic [3:0] ud[3];
    bit         all_eq;
    bit         occupied;
    logic [3:0] exp_dev;
    PDP1 = p1; PDP2 = p2; PDP3 = p3;
    UEP1 = u1; UEP2 = u2; UEP3 = u3;
    Motion_Sensor = mot; Fire_Detector = fir; Remote = rem;
    pd = '{p1, p2, p3};
    ud = '{u1, u2, u3};
    all_eq = 1'b1;
    foreach (pd[k]) if (pd[k] != ud[k]) all_eq = 1'b0;
    if (mot) begin
      quiet = 0;
      seen_motion = 1'b1;
    end else begin
      quiet++;
    end
`ifdef SMART_HOME_IDLE_TIMEOUT_EN
    occupied = mot || (seen_motion && quiet <= IDLE_CYCLES);
`else
    occupied = mot;
`endif
    exp_dev = (fir || !all_eq || !occupied) ? 4'h0 : rem;
    @(posedge clk);
    #1;
    check({tag, ".M"}, {7'd0, M}, {7'd0, all_eq});
    check({tag, ".Devices"}, {4'd0, Devices}, {4'd0, exp_dev});
  endtask

  task automatic model_reset();
    quiet = 1000000;
    seen_motion = 1'b0;
  endtask

  initial begin
    logic [3:0] p[3];
    logic [3:0] u[3];
    rst = 1'b1;
    Motion_Sensor = 1'b0; Fire_Detector = 1'b0; Remote = 4'h0;
    PDP1 = 4'h0; PDP2 = 4'h0; PDP3 = 4'h0;
    UEP1 = 4'h1; UEP2 = 4'h0; UEP3 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.M", {7'd0, M}, 8'd0);
    check("reset.Devices", {4'd0, Devices}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    cycle(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0110, "zero_codes");
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3, 1'b1, 1'b0, 4'b1010, "match");
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h2, 1'b1, 1'b0, 4'b1010, "uep3_wrong");
    cycle(4'h5, 4'hA, 4'h3, 4'h4, 4'hA, 4'h3, 1'b1, 1'b0, 4'b1111, "uep1_bit0");
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'h2, 4'h3, 1'b1, 1'b0, 4'b1111, "uep2_bit3");
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3, 1'b1, 1'b1, 4'b1010, "fire");
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3, 1'b1, 1'b0, 4'b1010, "fire_drop");
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3, 1'b0, 1'b0, 4'b1010, "no_motion");
    for (int i = 0; i < IDLE_CYCLES + 1; i++)
      cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3, 1'b0, 1'b0, 4'b1010, "idle_run");

    // Async reset in the middle of a clock phase with all devices on.
    cycle(4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3, 1'b1, 1'b0, 4'b1111, "all_on");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.M", {7'd0, M}, 8'd0);
    check("async_rst.Devices", {4'd0, Devices}, 8'd0);
    @(posedge clk);
    #1;
    check("rst_held.Devices", {4'd0, Devices}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 3; k++) begin
        p[k] = 4'($urandom_range(15, 0));
        u[k] = p[k];
      end
      if ($urandom_range(1, 0) == 1) begin
        int d;
        d = $urandom_range(2, 0);
        if ($urandom_range(1, 0) == 1) u[d] = p[d] ^ (4'h1 << $urandom_range(3, 0));
        else u[d] = 4'($urandom_range(15, 0));
      end
      cycle(p[0], p[1], p[2], u[0], u[1], u[2],
            1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) == 0),
            4'($urandom_range(15, 0)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_smart_home_main

`default_nettype wire
